// File: rtl/ysyx_24100012_wbu.sv
// Write-back unit: the only driver of the register-file write port.
// Merges single-cycle EXU results with at most one outstanding LSU load,
// formats load data (byte/half/word, sign/zero extension), and exports a busy
// scoreboard so decode can stall on hazards against the in-flight load.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   exu_valid/ready          EXU result handshake; exu_wen/exu_rd/exu_data payload
//   ld_issue, ld_issue_*     load issue pulse with destination, funct3, byte offset
//   ld_slot_free             no load outstanding, ld_issue is legal
//   ld_rsp_valid/ready       LSU response handshake; ld_rsp_data/ld_rsp_err payload
//   ld_err                   one-cycle pulse after a faulted load response
//   busy                     per-register pending-load flags (bit 0 always 0)
//   RegWEn/Index/Data        registered register-file write port
module ysyx_24100012_wbu #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned N_REG      = 32,
  parameter int unsigned INDEX_LEN  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  exu_valid,
  output logic                  exu_ready,
  input  logic                  exu_wen,
  input  logic [INDEX_LEN-1:0]  exu_rd,
  input  logic [DATA_WIDTH-1:0] exu_data,
  input  logic                  ld_issue,
  input  logic [INDEX_LEN-1:0]  ld_issue_rd,
  input  logic [2:0]            ld_issue_fmt,
  input  logic [1:0]            ld_issue_off,
  output logic                  ld_slot_free,
  input  logic                  ld_rsp_valid,
  output logic                  ld_rsp_ready,
  input  logic [DATA_WIDTH-1:0] ld_rsp_data,
  input  logic                  ld_rsp_err,
  output logic                  ld_err,
  output logic [N_REG-1:0]      busy,
  output logic                  RegWEn,
  output logic [INDEX_LEN-1:0]  RegWriteIndex,
  output logic [DATA_WIDTH-1:0] RegWriteData
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_COMMIT
  } state_e;

  state_e                state_q, state_d;
  logic [INDEX_LEN-1:0]  rd_q, rd_d;
  logic [2:0]            fmt_q, fmt_d;
  logic [1:0]            off_q, off_d;
  logic [N_REG-1:0]      busy_q, busy_d;
  logic                  wen_q, wen_d;
  logic [INDEX_LEN-1:0]  idx_q, idx_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  err_q, err_d;

  logic                  ld_hs;
  logic                  exu_hs;
  logic                  waw;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [DATA_WIDTH-1:0] ld_fmt;

  // EXU must not overtake an in-flight load to the same rd (in-order retire).
  assign waw          = exu_valid & exu_wen & busy_q[exu_rd];
  assign ld_slot_free = (state_q == S_IDLE);
  assign ld_rsp_ready = (state_q == S_WAIT);
  assign ld_hs        = ld_rsp_valid & ld_rsp_ready;
  assign exu_ready    = ~((state_q == S_WAIT) & ld_rsp_valid) & ~waw;
  assign exu_hs       = exu_valid & exu_ready;

  // Load lane selection and extension.
  always_comb begin
    byte_sel = ld_rsp_data[7:0];
    case (off_q)
      2'd1:    byte_sel = ld_rsp_data[15:8];
      2'd2:    byte_sel = ld_rsp_data[23:16];
      2'd3:    byte_sel = ld_rsp_data[31:24];
      default: byte_sel = ld_rsp_data[7:0];
    endcase
    half_sel = off_q[1] ? ld_rsp_data[31:16] : ld_rsp_data[15:0];
    case (fmt_q)
      3'b000:  ld_fmt = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
      3'b001:  ld_fmt = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
      3'b100:  ld_fmt = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
      3'b101:  ld_fmt = {{(DATA_WIDTH-16){1'b0}}, half_sel};
      default: ld_fmt = ld_rsp_data;
    endcase
  end

  // Slot FSM and scoreboard.
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    fmt_d   = fmt_q;
    off_d   = off_q;
    busy_d  = busy_q;
    case (state_q)
      S_IDLE: begin
        if (ld_issue) begin
          state_d = S_WAIT;
          rd_d    = ld_issue_rd;
          fmt_d   = ld_issue_fmt;
          off_d   = ld_issue_off;
          if (ld_issue_rd != '0) busy_d[ld_issue_rd] = 1'b1;
        end
      end
      S_WAIT: begin
        if (ld_hs) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        // Cleared one cycle after RegWEn so a reader seeing busy=0 sees the new value.
        state_d      = S_IDLE;
        busy_d[rd_q] = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d[0] = 1'b0;
  end

  // Write-port arbitration: load response has priority (exu_ready is low then).
  always_comb begin
    wen_d  = 1'b0;
    idx_d  = idx_q;
    data_d = data_q;
    err_d  = 1'b0;
    if (ld_hs) begin
      err_d = ld_rsp_err;
      if (!ld_rsp_err && rd_q != '0) begin
        wen_d  = 1'b1;
        idx_d  = rd_q;
        data_d = ld_fmt;
      end
    end else if (exu_hs && exu_wen && exu_rd != '0) begin
      wen_d  = 1'b1;
      idx_d  = exu_rd;
      data_d = exu_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      rd_q    <= '0;
      fmt_q   <= '0;
      off_q   <= '0;
      busy_q  <= '0;
      wen_q   <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      fmt_q   <= fmt_d;
      off_q   <= off_d;
      busy_q  <= busy_d;
      wen_q   <= wen_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign busy          = busy_q;
  assign RegWEn        = wen_q;
  assign RegWriteIndex = idx_q;
  assign RegWriteData  = data_q;
  assign ld_err        = err_q;

endmodule
